// File: rtl/core_sequencer_pkg.sv
// Shared types for the riscalar multi-cycle control path.
// Holds the decoded instruction class and the sequencer state encoding.
package core_sequencer_pkg;

  typedef enum logic [3:0] {
    OP, OPIMM, BRANCH, LUI, AUIPC, JAL, JALR, LOAD, STORE, Unsupported
  } IType;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXECUTE, MEM, WB, HALT
  } SeqState;

  function automatic logic is_mem_op(IType t);
    return (t == LOAD) || (t == STORE);
  endfunction

  function automatic logic writes_rf(IType t);
    return !((t == STORE) || (t == BRANCH));
  endfunction

endpackage

// File: rtl/core_sequencer_wait.sv
// BRAM latency timer shared by instruction fetch and data loads.
// Counts from 0 up to MEM_LATENCY while enabled and parks there until cleared.
module mem_wait_timer #(
  parameter int MEM_LATENCY = 2
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear,
  input  logic enable,
  output logic first,
  output logic done
);

  localparam int CW = $clog2(MEM_LATENCY + 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_in) begin
    if (rst_in || clear) begin
      cnt <= '0;
    end else if (enable && !done) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign first = (cnt == '0);
  assign done  = (cnt == CW'(MEM_LATENCY));

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer for the riscalar core.
// Optional macro CORE_SEQ_PERF_EN adds busy-cycle and retired-instruction counters.
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic        stop_in,
  input  IType        iType_in,
  output logic        imem_en_out,
  output logic        ir_we_out,
  output logic        dmem_en_out,
  output logic        dmem_we_out,
  output logic        rf_we_out,
  output logic        pc_we_out,
  output logic        instret_out,
  output logic        busy_out,
  output logic        halted_out,
`ifdef CORE_SEQ_PERF_EN
  output logic [31:0] cycle_count_out,
  output logic [31:0] instret_count_out,
`endif
  output SeqState     state_out
);

  SeqState state, state_next;
  IType    itype_q;
  logic    tmr_en, tmr_first, tmr_done;

  // The timer only runs in FETCH and in the MEM phase of a load; any other
  // state holds it at zero, so it always starts fresh on entry.
  assign tmr_en = (state == FETCH) || ((state == MEM) && (itype_q == LOAD));

  mem_wait_timer #(.MEM_LATENCY(MEM_LATENCY)) u_timer (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clear  (!tmr_en),
    .enable (tmr_en),
    .first  (tmr_first),
    .done   (tmr_done)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state   <= IDLE;
      itype_q <= OP;
    end else begin
      state <= state_next;
      if (state == DECODE) itype_q <= iType_in;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path through the block leaves a variable unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_in) state_next = FETCH;
      FETCH:   if (tmr_done) state_next = DECODE;
      DECODE:  state_next = (iType_in == Unsupported) ? HALT : EXECUTE;
      EXECUTE: state_next = is_mem_op(itype_q) ? MEM : WB;
      MEM:     if ((itype_q == STORE) || tmr_done) state_next = WB;
      WB:      state_next = stop_in ? IDLE : FETCH;
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    imem_en_out = 1'b0;
    ir_we_out   = 1'b0;
    dmem_en_out = 1'b0;
    dmem_we_out = 1'b0;
    rf_we_out   = 1'b0;
    pc_we_out   = 1'b0;
    instret_out = 1'b0;
    unique case (state)
      FETCH: begin
        imem_en_out = tmr_first;
        ir_we_out   = tmr_done;
      end
      MEM: begin
        dmem_en_out = (itype_q == LOAD) && tmr_first;
        dmem_we_out = (itype_q == STORE);
      end
      WB: begin
        rf_we_out   = writes_rf(itype_q);
        pc_we_out   = 1'b1;
        instret_out = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy_out   = (state != IDLE) && (state != HALT);
  assign halted_out = (state == HALT);
  assign state_out  = state;

`ifdef CORE_SEQ_PERF_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cycle_count_out   <= '0;
      instret_count_out <= '0;
    end else begin
      if (busy_out)    cycle_count_out   <= cycle_count_out + 32'd1;
      if (instret_out) instret_count_out <= instret_count_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: cycle-by-cycle vector table for MEM_LATENCY=2
// plus hand-written length, store-pulse and (with CORE_SEQ_PERF_EN) counter sequences.
module tb_core_sequencer;
  import core_sequencer_pkg::*;

  localparam int L = 2;

  logic    clk_in = 1'b0;
  logic    rst_in, start_in, stop_in;
  IType    iType_in;
  logic    imem_en_out, ir_we_out, dmem_en_out, dmem_we_out;
  logic    rf_we_out, pc_we_out, instret_out, busy_out, halted_out;
  SeqState state_out;
`ifdef CORE_SEQ_PERF_EN
  logic [31:0] cycle_count_out, instret_count_out;
`endif

  core_sequencer #(.MEM_LATENCY(L)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .start_in          (start_in),
    .stop_in           (stop_in),
    .iType_in          (iType_in),
    .imem_en_out       (imem_en_out),
    .ir_we_out         (ir_we_out),
    .dmem_en_out       (dmem_en_out),
    .dmem_we_out       (dmem_we_out),
    .rf_we_out         (rf_we_out),
    .pc_we_out         (pc_we_out),
    .instret_out       (instret_out),
    .busy_out          (busy_out),
    .halted_out        (halted_out),
`ifdef CORE_SEQ_PERF_EN
    .cycle_count_out   (cycle_count_out),
    .instret_count_out (instret_count_out),
`endif
    .state_out         (state_out)
  );

  always #5 clk_in = ~clk_in;

  // Output bundle: {imem_en, ir_we, dmem_en, dmem_we, rf_we, pc_we, instret, busy, halted}
  localparam logic [8:0] O_IDLE = 9'b0000000_00;
  localparam logic [8:0] O_BUSY = 9'b0000000_10;
  localparam logic [8:0] O_IMEM = 9'b1000000_10;
  localparam logic [8:0] O_IRWE = 9'b0100000_10;
  localparam logic [8:0] O_DMEN = 9'b0010000_10;
  localparam logic [8:0] O_DMWE = 9'b0001000_10;
  localparam logic [8:0] O_WB   = 9'b0000111_10;
  localparam logic [8:0] O_WBNR = 9'b0000011_10;
  localparam logic [8:0] O_HALT = 9'b0000000_01;

  typedef struct {
    logic    rst;
    logic    start;
    logic    stop;
    IType    itype;
    SeqState st;
    logic [8:0] outs;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] dut_outs();
    return {imem_en_out, ir_we_out, dmem_en_out, dmem_we_out,
            rf_we_out, pc_we_out, instret_out, busy_out, halted_out};
  endfunction

  task automatic add(input logic r, input logic s, input logic p, input IType t,
                     input SeqState st, input logic [8:0] o);
    vec_t v;
    v.rst = r; v.start = s; v.stop = p; v.itype = t; v.st = st; v.outs = o;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic r, input logic s, input logic p, input IType t);
    rst_in = r; start_in = s; stop_in = p; iType_in = t;
  endtask

  // Runs one instruction from IDLE with stop_in=1 and measures it.
  task automatic run_instr(input IType t, output int cycles, output int dmwe, output int rfwe);
    cycles = 0; dmwe = 0; rfwe = 0;
    drive(1'b0, 1'b1, 1'b1, t);
    step();
    start_in = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!busy_out) break;
      cycles++;
      dmwe += int'(dmem_we_out);
      rfwe += int'(rf_we_out);
      step();
    end
    check("instr_timeout_busy", 32'(busy_out), 32'd0);
  endtask

  initial begin
    int cyc, dmwe, rfwe;
    IType kinds[5];

    drive(1'b1, 1'b0, 1'b0, OP);

    // OP, stop at end; start also raised during EXECUTE to show it is ignored
    add(1,0,1,OP, IDLE,    O_IDLE);
    add(0,1,1,OP, FETCH,   O_IMEM);
    add(0,0,1,OP, FETCH,   O_BUSY);
    add(0,0,1,OP, FETCH,   O_IRWE);
    add(0,0,1,OP, DECODE,  O_BUSY);
    add(0,0,1,OP, EXECUTE, O_BUSY);
    add(0,1,1,OP, WB,      O_WB);
    add(0,0,1,OP, IDLE,    O_IDLE);
    // LOAD: three MEM cycles, dmem_en only in the first
    add(0,1,1,LOAD, FETCH,   O_IMEM);
    add(0,0,1,LOAD, FETCH,   O_BUSY);
    add(0,0,1,LOAD, FETCH,   O_IRWE);
    add(0,0,1,LOAD, DECODE,  O_BUSY);
    add(0,0,1,LOAD, EXECUTE, O_BUSY);
    add(0,0,1,LOAD, MEM,     O_DMEN);
    add(0,0,1,LOAD, MEM,     O_BUSY);
    add(0,0,1,LOAD, MEM,     O_BUSY);
    add(0,0,1,LOAD, WB,      O_WB);
    add(0,0,1,LOAD, IDLE,    O_IDLE);
    // STORE: single write cycle, no register write-back
    add(0,1,1,STORE, FETCH,   O_IMEM);
    add(0,0,1,STORE, FETCH,   O_BUSY);
    add(0,0,1,STORE, FETCH,   O_IRWE);
    add(0,0,1,STORE, DECODE,  O_BUSY);
    add(0,0,1,STORE, EXECUTE, O_BUSY);
    add(0,0,1,STORE, MEM,     O_DMWE);
    add(0,0,1,STORE, WB,      O_WBNR);
    add(0,0,1,STORE, IDLE,    O_IDLE);
    // BRANCH with stop=0 chains straight into an OP
    add(0,1,0,BRANCH, FETCH,   O_IMEM);
    add(0,0,0,BRANCH, FETCH,   O_BUSY);
    add(0,0,0,BRANCH, FETCH,   O_IRWE);
    add(0,0,0,BRANCH, DECODE,  O_BUSY);
    add(0,0,0,BRANCH, EXECUTE, O_BUSY);
    add(0,0,0,BRANCH, WB,      O_WBNR);
    add(0,0,0,OP,     FETCH,   O_IMEM);
    add(0,0,1,OP,     FETCH,   O_BUSY);
    add(0,0,1,OP,     FETCH,   O_IRWE);
    add(0,0,1,OP,     DECODE,  O_BUSY);
    add(0,0,1,OP,     EXECUTE, O_BUSY);
    add(0,0,1,OP,     WB,      O_WB);
    add(0,0,1,OP,     IDLE,    O_IDLE);
    // Unsupported: sticky HALT, start ignored, reset recovers
    add(0,1,1,Unsupported, FETCH,  O_IMEM);
    add(0,0,1,Unsupported, FETCH,  O_BUSY);
    add(0,0,1,Unsupported, FETCH,  O_IRWE);
    add(0,0,1,Unsupported, DECODE, O_BUSY);
    add(0,0,1,Unsupported, HALT,   O_HALT);
    for (int i = 0; i < 5; i++) add(0,1,1,OP, HALT, O_HALT);
    add(1,0,1,OP, IDLE, O_IDLE);
    add(0,0,1,OP, IDLE, O_IDLE);
    // Reset in STORE EXECUTE: the write never happens
    add(0,1,1,STORE, FETCH,   O_IMEM);
    add(0,0,1,STORE, FETCH,   O_BUSY);
    add(0,0,1,STORE, FETCH,   O_IRWE);
    add(0,0,1,STORE, DECODE,  O_BUSY);
    add(0,0,1,STORE, EXECUTE, O_BUSY);
    add(1,0,1,STORE, IDLE,    O_IDLE);
    add(0,0,1,STORE, IDLE,    O_IDLE);
    add(0,0,1,STORE, IDLE,    O_IDLE);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].itype);
      step();
      check($sformatf("v%0d_state", i), 32'(state_out), 32'(vecs[i].st));
      check($sformatf("v%0d_outs", i), 32'(dut_outs()), 32'(vecs[i].outs));
      check($sformatf("v%0d_excl", i),
            32'(int'(imem_en_out) + int'(dmem_en_out) + int'(dmem_we_out) <= 1), 32'd1);
    end

    // Instruction lengths for the configured latency
    kinds = '{OP, JAL, BRANCH, LOAD, STORE};
    for (int k = 0; k < 5; k++) begin
      run_instr(kinds[k], cyc, dmwe, rfwe);
      check($sformatf("len_%s", kinds[k].name()), 32'(cyc),
            (kinds[k] == LOAD) ? 32'(2*L+5) : (kinds[k] == STORE) ? 32'(L+5) : 32'(L+4));
      check($sformatf("dmwe_%s", kinds[k].name()), 32'(dmwe),
            (kinds[k] == STORE) ? 32'd1 : 32'd0);
      check($sformatf("rfwe_%s", kinds[k].name()), 32'(rfwe),
            (kinds[k] == STORE || kinds[k] == BRANCH) ? 32'd0 : 32'd1);
    end

`ifdef CORE_SEQ_PERF_EN
    begin
      int retired;
      retired = 0;
      drive(1'b1, 1'b0, 1'b0, OP);
      step();
      check("perf_reset_cycles", cycle_count_out, 32'd0);
      check("perf_reset_instret", instret_count_out, 32'd0);
      drive(1'b0, 1'b1, 1'b0, OP);
      step();
      start_in = 1'b0;
      for (int i = 0; i < 200; i++) begin
        if (instret_out) retired++;
        stop_in = (retired >= 2);
        step();
        if (state_out == IDLE) break;
      end
      check("perf_back_to_idle", 32'(state_out), 32'(IDLE));
      check("perf_instret_count", instret_count_out, 32'd2);
      check("perf_cycle_count", cycle_count_out, 32'(2*(L+4)));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Multi-cycle control FSM for the riscalar core.
- Steps one instruction at a time through FETCH, DECODE, EXECUTE, MEM and WB.
- Drives the write and read enables of the PC, IR, register file, instruction memory and data memory.
- Consumes the decoded IType from the decode stage.
- Hides fixed BRAM read latency with an internal wait counter.

Parameters:
- MEM_LATENCY, 2, read latency of both the instruction and data BRAMs in cycles; must be >= 1.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- start_in  input  1  begin execution; sampled only in IDLE
- stop_in  input  1  return to IDLE at end of the current instruction; sampled in WB
- iType_in  input  IType  decoded instruction type; valid in DECODE and later
- imem_en_out  output  1  instruction BRAM read enable
- ir_we_out  output  1  latch the IR from BRAM data
- dmem_en_out  output  1  data BRAM read enable
- dmem_we_out  output  1  data BRAM write enable
- rf_we_out  output  1  register-file write enable
- pc_we_out  output  1  PC update enable
- instret_out  output  1  one-cycle pulse per retired instruction
- busy_out  output  1  high in any state other than IDLE and HALT
- halted_out  output  1  high in HALT (illegal instruction)
- state_out  output  SeqState  current state, for debug

Behaviour:
- One clock: clk_in. Reset: rst_in, synchronous, active-high.
- Registers: state, a latched copy of IType, and wait counter cnt (width $clog2(MEM_LATENCY+1)).
- All outputs are decoded combinationally from these registers; there are no combinational input-to-output paths.
- Reset, including mid-operation: on the next clock edge state=IDLE and cnt=0, so every enable and pulse is 0 from the following cycle.
  - An in-flight store is dropped; dmem_we_out is never asserted after rst_in is sampled.
- IDLE:
  - start_in=1 -> FETCH with cnt=0.
  - start_in is ignored in every other state.
- FETCH:
  - imem_en_out=1 when cnt==0.
  - cnt increments every cycle.
  - When cnt==MEM_LATENCY: ir_we_out=1, then -> DECODE.
  - FETCH therefore lasts MEM_LATENCY+1 cycles.
- DECODE (1 cycle):
  - Latch iType_in.
  - iType_in==Unsupported -> HALT.
  - Otherwise -> EXECUTE.
- EXECUTE (1 cycle):
  - Latched type LOAD or STORE -> MEM with cnt=0.
  - Otherwise -> WB.
- MEM, LOAD:
  - dmem_en_out=1 when cnt==0.
  - When cnt==MEM_LATENCY -> WB (MEM_LATENCY+1 cycles total).
- MEM, STORE:
  - dmem_we_out=1 for exactly 1 cycle, then -> WB.
- WB (1 cycle):
  - pc_we_out=1 and instret_out=1.
  - rf_we_out=1 unless the latched type is STORE or BRANCH.
  - stop_in=1 -> IDLE; otherwise -> FETCH with cnt=0.
- HALT:
  - Sticky; halted_out=1 and all enables are 0.
  - Only rst_in exits HALT.
- Instruction lengths for MEM_LATENCY=L:
  - OP, OPIMM, LUI, AUIPC, JAL, JALR, BRANCH: L+4 cycles.
  - LOAD: 2L+5 cycles.
  - STORE: L+5 cycles.
- At most one enable among imem_en_out, dmem_en_out and dmem_we_out is high in any cycle.

Optional Feature:
- Macro: CORE_SEQ_PERF_EN.
- When defined, adds two output ports:
  - cycle_count_out[31:0]: increments every cycle busy_out=1.
  - instret_count_out[31:0]: increments on each instret_out.
  - Both counters reset to 0 on rst_in and wrap modulo 2^32.
- When undefined, both ports and their logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package: IType, which already exists in types.svh with members OP, OPIMM, BRANCH, LUI, AUIPC, JAL, JALR, LOAD, STORE and Unsupported.
- Add to the same package: SeqState enum {IDLE, FETCH, DECODE, EXECUTE, MEM, WB, HALT}.
- Sub-module: mem_wait_timer, parameterised by MEM_LATENCY.
  - Inputs: clear, enable.
  - Output: done (asserted when cnt==MEM_LATENCY).
  - Shared by FETCH and LOAD.

Test Plan:
- Reset, L=2, start_in pulse, iType_in=OP, stop_in=1:
  - imem_en at cycle 0 and ir_we at cycle 2 after FETCH entry; DECODE cycle 3, EXECUTE 4, WB 5.
  - In WB: rf_we=pc_we=instret=1; then IDLE, busy=0.
- iType_in=LOAD, L=2: dmem_en in the first MEM cycle, MEM lasts 3 cycles, rf_we=1 in WB, 9 cycles total.
- iType_in=STORE: dmem_we=1 for exactly 1 cycle; WB has rf_we=0 and pc_we=1; 7 cycles total. BRANCH: rf_we=0 in WB.
- iType_in=Unsupported: HALT after DECODE with halted_out=1; start_in=1 for 5 cycles gives no change; rst_in then returns to IDLE.
- rst_in asserted during STORE EXECUTE: the next cycle is IDLE with all outputs 0, and dmem_we is never seen.
- CORE_SEQ_PERF_EN defined, L=2, two OP instructions back to back then stop: instret_count_out=2, cycle_count_out=12.
